// File: rtl/karatsuba_34x43_stream_ctrl.sv
// karatsuba_34x43_stream_ctrl: valid/ready wrapper around a fixed-latency 34x43 multiplier
// with a credit-protected result FIFO so backpressure never drops a product.
module karatsuba_34x43_stream_ctrl #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [33:0] s_a,
    input  logic [42:0] s_b,
    output logic [33:0] mul_a,
    output logic [42:0] mul_b,
    input  logic [76:0] mul_c,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [76:0] m_c,
    output logic [5:0]  inflight
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [5:0]    credits;
    logic [CW-1:0] count;
    logic [CW-1:0] remaining;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [LATENCY:0] vline;
    logic [76:0]   mem [DEPTH];
    logic [76:0]   head;
    logic          fire_in;
    logic          fire_out;
    logic          cap_en;

    assign s_ready   = rst && (credits < 6'(DEPTH));
    assign fire_in   = s_valid && s_ready;
    assign m_valid   = count != '0;
    assign fire_out  = m_valid && m_ready;
    assign cap_en    = vline[LATENCY];
    assign inflight  = credits;
    assign rd_next   = rd_ptr + AW'(fire_out);
    assign remaining = count - CW'(fire_out);
    // Next head: a captured product lands directly in the output register when the FIFO drains to empty.
    assign head      = remaining != '0 ? mem[rd_next] : (cap_en ? mul_c : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= '0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vline   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            m_c     <= '0;
        end else begin
            credits <= credits + 6'(fire_in) - 6'(fire_out);
            count   <= count + CW'(cap_en) - CW'(fire_out);
            wr_ptr  <= wr_ptr + AW'(cap_en);
            rd_ptr  <= rd_next;
            vline   <= {vline[LATENCY-1:0], fire_in};
            m_c     <= head;
            if (fire_in) begin
                mul_a <= s_a;
                mul_b <= s_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en)
            mem[wr_ptr] <= mul_c;
    end
endmodule

// File: tb/tb_karatsuba_34x43_stream_ctrl.sv
// tb_karatsuba_34x43_stream_ctrl: scoreboard bench with a behavioural fixed-latency multiplier.
module tb_karatsuba_34x43_stream_ctrl #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
);
    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [33:0] s_a;
    logic [42:0] s_b;
    logic [33:0] mul_a;
    logic [42:0] mul_b;
    logic [76:0] mul_c;
    logic        m_valid;
    logic        m_ready;
    logic [76:0] m_c;
    logic [5:0]  inflight;

    karatsuba_34x43_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .m_valid(m_valid), .m_ready(m_ready),
        .m_c(m_c), .inflight(inflight)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Multiplier stand-in: pure pipeline of LATENCY stages, no stall path.
    logic [76:0] pipe [LATENCY];
    always_ff @(posedge clk) begin
        pipe[0] <= {43'b0, mul_a} * {34'b0, mul_b};
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_c = pipe[LATENCY-1];

    logic [76:0] exp_q [$];
    logic [76:0] cur_exp;
    int tests = 0, fails = 0;
    int cyc = 0, acc_cnt = 0, out_cnt = 0, stalls = 0, max_infl = 0;
    int first_in = -1, first_valid = -1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (int'(inflight) > max_infl) max_infl = int'(inflight);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (s_valid && s_ready) begin
                exp_q.push_back(cur_exp);
                acc_cnt++;
                if (first_in < 0) first_in = cyc;
            end
            if (m_valid && m_ready) begin
                out_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result got %h, none expected", m_c);
                end else begin
                    automatic logic [76:0] e = exp_q.pop_front();
                    if (m_c !== e) begin
                        fails++;
                        $display("FAIL result got %h, expected %h", m_c, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [76:0] got, input logic [76:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [33:0] a, input logic [42:0] b, input logic [76:0] e);
        int n = 0;
        s_valid = 1; s_a = a; s_b = b; cur_exp = e;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (!s_ready) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        s_valid = 0;
    endtask

    task automatic send_rand();
        logic [33:0] a = 34'({$urandom(), $urandom()});
        logic [42:0] b = 43'({$urandom(), $urandom()});
        send(a, b, {43'b0, a} * {34'b0, b});
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 77'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        rst = 0; s_valid = 0; m_ready = 1; s_a = '0; s_b = '0; cur_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 77'(s_ready), 0);
        chk("rst_m_valid", 77'(m_valid), 0);
        chk("rst_m_c", m_c, 0);
        chk("rst_inflight", 77'(inflight), 0);
        chk("rst_mul_a", 77'(mul_a), 0);
        chk("rst_mul_b", 77'(mul_b), 0);
        rst = 1;
        #1;
        chk("ready_after_rst", 77'(s_ready), 1);

        // single max*max op: exact value and latency
        send(34'h3_FFFF_FFFF, 43'h7FF_FFFF_FFFF, 77'h1FFF_FFFF_F7FC_0000_0001);
        repeat (LATENCY + 10) @(posedge clk);
        #1;
        chk("latency", 77'(first_valid - first_in), 77'(LATENCY + 2));
        chk("single_count", 77'(out_cnt), 1);

        send(34'h0, 43'h123, 77'h0);
        send(34'h1, 43'h7FF_FFFF_FFFF, 77'h7FF_FFFF_FFFF);
        send(34'h2, 43'h3, 77'h6);
        send(34'h1_0000_0000, 43'h100, 77'h100_0000_0000);
        send(34'h3_FFFF_FFFF, 43'h2, 77'h7_FFFF_FFFE);
        drain("directed_drain", 100);

        // back-to-back stream
        stalls = 0;
        base = out_cnt;
        for (int i = 0; i < 100; i++) send_rand();
        drain("stream_drain", LATENCY + 3);
        chk("stream_stalls", 77'(stalls), 0);
        chk("stream_count", 77'(out_cnt - base), 100);

        // fill with downstream blocked
        m_ready = 0;
        base = acc_cnt;
        for (int i = 0; i < 30; i++) begin
            s_a = 34'({$urandom(), $urandom()});
            s_b = 43'({$urandom(), $urandom()});
            cur_exp = {43'b0, s_a} * {34'b0, s_b};
            s_valid = 1;
            @(posedge clk); #1;
        end
        s_valid = 0;
        chk("full_accepts", 77'(acc_cnt - base), 77'(DEPTH));
        chk("full_s_ready", 77'(s_ready), 0);
        chk("full_inflight", 77'(inflight), 77'(DEPTH));
        base = out_cnt;
        m_ready = 1;
        #1;
        chk("ready_indep_m_ready", 77'(s_ready), 0);
        @(posedge clk); #1;
        chk("ready_after_pop", 77'(s_ready), 1);
        drain("full_drain", 100);
        chk("full_results", 77'(out_cnt - base), 77'(DEPTH));
        for (int i = 0; i < 4; i++) send_rand();
        drain("resume_drain", 100);

        // random backpressure and random valid
        max_infl = 0;
        for (int i = 0; i < 300; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            s_a = 34'({$urandom(), $urandom()});
            s_b = 43'({$urandom(), $urandom()});
            cur_exp = {43'b0, s_a} * {34'b0, s_b};
            s_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        s_valid = 0;
        m_ready = 1;
        drain("random_drain", 200);
        chk("max_inflight_ok", 77'(max_infl <= DEPTH), 1);

        // reset with products in flight and buffered
        m_ready = 0;
        for (int i = 0; i < DEPTH; i++) send_rand();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("mid_rst_m_valid", 77'(m_valid), 0);
        chk("mid_rst_inflight", 77'(inflight), 0);
        chk("mid_rst_m_c", m_c, 0);
        chk("mid_rst_s_ready", 77'(s_ready), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        m_ready = 1;
        base = out_cnt;
        repeat (LATENCY + 20) @(posedge clk);
        #1;
        chk("no_ghost_output", 77'(out_cnt - base), 0);
        send(34'h5, 43'h7, 77'h23);
        drain("post_rst_drain", 100);
        chk("post_rst_count", 77'(out_cnt - base), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
